// File: rtl/uc_pkg.sv
// Types and widths shared by the fetch and data-memory paths.
package uc_pkg;
    typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, VALID} fetch_state_t;

    localparam int INSTR_WIDTH      = 16;
    localparam int FLASH_DATA_WIDTH = 8;
    localparam int WAIT_CNT_WIDTH   = 3;
endpackage

// File: rtl/fetch_pending_reg.sv
// Single-entry address holding register with a valid flag; clear wins over load.
module fetch_pending_reg #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] addr_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] addr_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] addr_q, addr_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads a big-endian 16-bit word as two flash bytes with fixed
// wait states and hands it to the decoder over a valid/ready handshake.
module instr_fetch
    import uc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 2
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic [ADDR_WIDTH-1:0]       pc_addr,
    input  logic                        pc_valid,
    output logic                        flash_ready,
    input  logic                        flush,
    output logic [ADDR_WIDTH:0]         flash_addr,
    output logic                        flash_rd,
    input  logic [FLASH_DATA_WIDTH-1:0] flash_rdata,
    output logic [INSTR_WIDTH-1:0]      instr,
    output logic [ADDR_WIDTH-1:0]       instr_pc,
    output logic                        instr_valid,
    input  logic                        instr_ready
);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST = WAIT_CNT_WIDTH'(WAIT_STATES);

    fetch_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]     cur_addr_q, cur_addr_d;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]     instr_pc_q, instr_pc_d;
    logic [ADDR_WIDTH:0]       flash_addr_q, flash_addr_d;
    logic                      flash_rd_q, flash_rd_d;
    logic                      instr_valid_q, instr_valid_d;

    logic                  pend_valid, pend_load, pend_clear;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic                  wait_done, handshake;

    fetch_pending_reg #(.WIDTH(ADDR_WIDTH)) u_pend (
        .clk     (clk),
        .arst_n  (arst_n),
        .load_i  (pend_load),
        .clear_i (pend_clear),
        .addr_i  (pc_addr),
        .valid_o (pend_valid),
        .addr_o  (pend_addr)
    );

    assign wait_done = (wait_cnt_q == WAIT_LAST);
    assign handshake = (state_q == VALID) && instr_ready;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        wait_cnt_d = wait_cnt_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pend_clear = 1'b0;
        // A PC update during a busy fetch is parked; a second one is dropped.
        pend_load  = !flush && pc_valid && (state_q != IDLE) && !pend_valid && !handshake;

        if (flush) begin
            pend_clear = 1'b1;
            wait_cnt_d = '0;
            if (pc_valid) begin
                cur_addr_d = pc_addr;
                state_d    = RD_HI;
            end else begin
                state_d    = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (pc_valid) begin
                        cur_addr_d = pc_addr;
                        state_d    = RD_HI;
                    end
                end
                RD_HI: begin
                    if (wait_done) begin
                        instr_d[15:8] = flash_rdata;
                        wait_cnt_d    = '0;
                        state_d       = RD_LO;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                RD_LO: begin
                    if (wait_done) begin
                        instr_d[7:0] = flash_rdata;
                        instr_pc_d   = cur_addr_q;
                        wait_cnt_d   = '0;
                        state_d      = VALID;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                VALID: begin
                    if (handshake) begin
                        if (pend_valid) begin
                            cur_addr_d = pend_addr;
                            pend_clear = 1'b1;
                            state_d    = RD_HI;
                        end else if (pc_valid) begin
                            cur_addr_d = pc_addr;
                            state_d    = RD_HI;
                        end else begin
                            state_d    = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        flash_rd_d    = (state_d == RD_HI) || (state_d == RD_LO);
        flash_addr_d  = flash_rd_d ? {cur_addr_d, (state_d == RD_LO)} : flash_addr_q;
        instr_valid_d = (state_d == VALID);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            wait_cnt_q    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            flash_addr_q  <= '0;
            flash_rd_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            flash_addr_q  <= flash_addr_d;
            flash_rd_q    <= flash_rd_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign flash_ready = (state_q == IDLE) && !pend_valid;
    assign flash_addr  = flash_addr_q;
    assign flash_rd    = flash_rd_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetches against a flash image,
// plus a zero-wait-state instance for the latency corner.
module tb_instr_fetch;
    typedef struct packed {
        logic [11:0] pc;
        logic [15:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [11:0] pc_addr;
    logic        pc_valid;
    logic        flash_ready;
    logic        flush;
    logic [12:0] flash_addr;
    logic        flash_rd;
    logic [7:0]  flash_rdata;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic        z_arst_n;
    logic [11:0] z_pc_addr;
    logic        z_pc_valid;
    logic        z_flash_ready;
    logic [12:0] z_flash_addr;
    logic        z_flash_rd;
    logic [7:0]  z_flash_rdata;
    logic [15:0] z_instr;
    logic [11:0] z_instr_pc;
    logic        z_instr_valid;

    logic [7:0] flash_mem [0:8191];
    exp_t       sb [$];
    int         n_vec  = 0;
    int         n_miss = 0;

    always #5 clk = ~clk;

    assign flash_rdata   = flash_mem[flash_addr];
    assign z_flash_rdata = flash_mem[z_flash_addr];

    instr_fetch #(.ADDR_WIDTH(12), .WAIT_STATES(2)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .pc_addr     (pc_addr),
        .pc_valid    (pc_valid),
        .flash_ready (flash_ready),
        .flush       (flush),
        .flash_addr  (flash_addr),
        .flash_rd    (flash_rd),
        .flash_rdata (flash_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    instr_fetch #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut_ws0 (
        .clk         (clk),
        .arst_n      (z_arst_n),
        .pc_addr     (z_pc_addr),
        .pc_valid    (z_pc_valid),
        .flash_ready (z_flash_ready),
        .flush       (1'b0),
        .flash_addr  (z_flash_addr),
        .flash_rd    (z_flash_rd),
        .flash_rdata (z_flash_rdata),
        .instr       (z_instr),
        .instr_pc    (z_instr_pc),
        .instr_valid (z_instr_valid),
        .instr_ready (1'b1)
    );

    // A second PC update while one is already parked breaks the PC protocol.
    always @(posedge clk)
        assert (!(arst_n && pc_valid && !flush && dut.pend_valid))
            else $error("pc_valid while pending entry occupied");

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Monitor: every decoder handshake must match the oldest expected fetch.
    always @(negedge clk) begin
        if (arst_n && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_instr: got pc %0h instr %0h expected none", instr_pc, instr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("instr@%0h", e.pc), {16'h0, instr}, {16'h0, e.ins});
                check($sformatf("instr_pc@%0h", e.pc), {20'h0, instr_pc}, {20'h0, e.pc});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [11:0] w, input logic [15:0] v);
        flash_mem[{w, 1'b0}] = v[15:8];
        flash_mem[{w, 1'b1}] = v[7:0];
    endtask

    // Issue (or complete an already-driven issue of) a fetch this cycle and
    // measure cycles to instr_valid plus the flash read pattern.
    task automatic measure(input logic [11:0] a, input logic [15:0] ins, input string nm);
        int lat, rd_n;
        logic [12:0] first_a, last_a;
        exp_t e;
        pc_addr  = a;
        pc_valid = 1'b1;
        e.pc = a;
        e.ins = ins;
        sb.push_back(e);
        lat = 0;
        rd_n = 0;
        first_a = '0;
        last_a = '0;
        do begin
            step();
            pc_valid = 1'b0;
            flush    = 1'b0;
            lat++;
            if (flash_rd) begin
                if (rd_n == 0) first_a = flash_addr;
                last_a = flash_addr;
                rd_n++;
            end
        end while (!instr_valid && lat < 40);
        check({nm, "_latency"}, lat, 7);
        check({nm, "_rd_cycles"}, rd_n, 6);
        check({nm, "_addr_hi"}, {19'h0, first_a}, {19'h0, a, 1'b0});
        check({nm, "_addr_lo"}, {19'h0, last_a}, {19'h0, a, 1'b1});
    endtask

    initial begin
        int c, c2, bad;
        exp_t e;
        for (int i = 0; i < 8192; i++) flash_mem[i] = 8'h00;
        put_word(12'h000, 16'hA53C);
        put_word(12'h010, 16'h1234);
        put_word(12'h011, 16'h5678);
        put_word(12'h050, 16'hCAFE);
        put_word(12'h100, 16'hDEAD);
        put_word(12'h101, 16'h0BAD);
        put_word(12'h200, 16'hBEEF);
        put_word(12'h300, 16'h1357);
        put_word(12'h301, 16'h2468);
        put_word(12'h7FF, 16'h9ABC);
        put_word(12'h123, 16'h4321);

        arst_n = 1'b0; z_arst_n = 1'b0;
        pc_addr = 12'h000; pc_valid = 1'b1; flush = 1'b0; instr_ready = 1'b1;
        z_pc_addr = 12'h000; z_pc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flash_ready", flash_ready, 1);
        check("rst_flash_rd", flash_rd, 0);
        check("rst_flash_addr", flash_addr, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, 0);

        // Boot: reset releases with the PC already presenting 0x000.
        arst_n = 1'b1; z_arst_n = 1'b1;
        measure(12'h000, 16'hA53C, "boot");
        step();

        // Back-to-back: second PC update lands one cycle later and is parked.
        pc_addr = 12'h010; pc_valid = 1'b1;
        e.pc = 12'h010; e.ins = 16'h1234; sb.push_back(e);
        step();
        pc_addr = 12'h011;
        e.pc = 12'h011; e.ins = 16'h5678; sb.push_back(e);
        c = 1; bad = 0;
        while (!instr_valid && c < 40) begin
            if (flash_ready) bad++;
            step();
            pc_valid = 1'b0;
            c++;
        end
        check("b2b_first_latency", c, 7);
        c2 = 0;
        do begin
            if (flash_ready) bad++;
            step();
            c2++;
        end while (!instr_valid && c2 < 40);
        if (flash_ready) bad++;
        check("b2b_second_after_hs", c2, 7);
        check("b2b_flash_ready_low", bad, 0);
        step();

        // Decoder stall: outputs frozen while instr_ready is low.
        instr_ready = 1'b0;
        measure(12'h050, 16'hCAFE, "stall");
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            if (instr !== 16'hCAFE || instr_pc !== 12'h050 || flash_rd !== 1'b0 || instr_valid !== 1'b1)
                bad++;
        end
        check("stall_stable", bad, 0);
        step();
        instr_ready = 1'b1;
        step();
        check("stall_hs_on_ready", instr_valid, 0);

        // Flush in RD_LO with the branch target in the same cycle.
        pc_addr = 12'h100; pc_valid = 1'b1;
        step();
        pc_addr = 12'h101;
        step();
        pc_valid = 1'b0;
        c = 0;
        while (!(flash_rd && flash_addr == 13'h201) && c < 40) begin
            step();
            c++;
        end
        check("flush_reached_rd_lo", {31'h0, flash_rd && flash_addr == 13'h201}, 1);
        flush = 1'b1;
        measure(12'h200, 16'hBEEF, "flush");
        step();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (flash_rd !== 1'b0 || instr_valid !== 1'b0 || flash_ready !== 1'b1) bad++;
            step();
        end
        check("flush_pending_dropped", bad, 0);

        // Reset in RD_HI with a pending entry.
        pc_addr = 12'h300; pc_valid = 1'b1;
        step();
        pc_addr = 12'h301;
        step();
        pc_valid = 1'b0;
        check("rst2_in_read", flash_rd, 1);
        #2;
        arst_n = 1'b0;
        #1;
        check("rst2_flash_rd", flash_rd, 0);
        check("rst2_flash_addr", flash_addr, 0);
        check("rst2_instr", instr, 0);
        check("rst2_instr_pc", instr_pc, 0);
        check("rst2_flash_ready", flash_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (flash_rd !== 1'b0 || flash_ready !== 1'b1 || instr_valid !== 1'b0) bad++;
        end
        check("rst2_pending_gone", bad, 0);
        measure(12'h7FF, 16'h9ABC, "top_word");
        step();

        // Zero wait states: two single-cycle reads, valid at t+3.
        z_pc_addr = 12'h123; z_pc_valid = 1'b1;
        c = 0; c2 = 0;
        do begin
            step();
            z_pc_valid = 1'b0;
            c++;
            if (z_flash_rd) c2++;
        end while (!z_instr_valid && c < 40);
        check("ws0_latency", c, 3);
        check("ws0_rd_cycles", c2, 2);
        check("ws0_instr", z_instr, 16'h4321);
        check("ws0_instr_pc", z_instr_pc, 12'h123);
        step();

        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage between the program counter and the decoder. Accepts each new PC value (`pc_valid`), reads the 16-bit instruction as two bytes from byte-wide program flash with a fixed number of wait states, and presents it to the decoder with a valid/ready handshake. Drives `flash_ready` back to the program counter so the PC advances only when the fetch stage can absorb the next address. A one-entry pending register covers the PC's one-cycle update latency.

## Interface
- `ADDR_WIDTH`, 12: instruction (word) address width; matches PC.
- `WAIT_STATES`, 2: extra cycles `flash_rd` is held before `flash_rdata` is sampled. Legal range 0–7.
- `clk` in 1: single clock; all logic rises on posedge.
- `arst_n` in 1: asynchronous, active-low reset.
- `pc_addr` in ADDR_WIDTH: PC value.
- `pc_valid` in 1: `pc_addr` is a new address to fetch; one-cycle pulse per update.
- `flash_ready` out 1: fetch stage can accept a PC advance.
- `flush` in 1: discard in-flight and pending fetches (taken branch).
- `flash_addr` out ADDR_WIDTH+1: byte address to flash.
- `flash_rd` out 1: flash read strobe.
- `flash_rdata` in 8: flash read data.
- `instr` out 16: fetched instruction.
- `instr_pc` out ADDR_WIDTH: word address of `instr`.
- `instr_valid` out 1: `instr`/`instr_pc` valid.
- `instr_ready` in 1: decoder accepts `instr`.

## Operation
- **States:** IDLE, RD_HI, RD_LO, VALID.
- **Byte order:** big-endian. The high byte is at `{addr,1'b0}` and the low byte at `{addr,1'b1}`.
- **Pending register:** `pend_valid` plus `pend_addr`. When `pc_valid` is high and the state is not IDLE, `pc_addr` is latched here.
- **IDLE:** `pc_valid` captures `pc_addr` into `cur_addr` and moves to RD_HI.
- **RD_HI:** `flash_rd`=1, `flash_addr`={cur_addr,0}. The wait counter counts `WAIT_STATES`. On the terminal cycle, `flash_rdata` is stored into `instr[15:8]`, the counter is cleared, and the state moves to RD_LO.
- **RD_LO:** same as RD_HI with `flash_addr`={cur_addr,1}. Data goes to `instr[7:0]`, `instr_pc`<=cur_addr, then VALID.
- **VALID:** `instr_valid`=1 and `flash_rd`=0. Outputs hold stable until `instr_ready`.
  - On handshake with `pend_valid`: load `cur_addr` from `pend_addr`, clear pending, go to RD_HI.
  - On handshake otherwise: go to IDLE.
  - A `pc_valid` arriving in the handshake cycle goes straight to `cur_addr` → RD_HI.
- **flash_ready:** combinational, = (state==IDLE) && !pend_valid. Pending therefore never exceeds one entry under legal PC behaviour.
- **Overflow:** `pc_valid` while `pend_valid` is set is a protocol violation. The new address is dropped and a bench assertion fires.
- **flush:** highest priority. Next state is IDLE, pending is cleared, `instr_valid` drops next cycle, and `flash_rd` deasserts next cycle.
  - If `pc_valid` is in the same cycle (the branch target), that address is captured and the next state is RD_HI.
- **Reset values:** state IDLE, `pend_valid`=0, `flash_rd`=0, `flash_addr`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, counter=0. `flash_ready`=1 during and after reset.
- **Boot:** the PC comes out of reset with `pc_valid`=1 at address 0x000. The first fetch therefore starts at 0x000 in the first cycle after reset release, with no special casing.

## Timing
- **Per byte:** `WAIT_STATES`+1 cycles of `flash_rd`. Data is sampled at the rising edge that ends the last cycle.
- **Fetch latency:** `pc_valid` in cycle t → `instr_valid` first high in cycle t+3+2·WAIT_STATES. With the default this is t+7.
- **Back-to-back:** the next `flash_rd` begins the cycle after the handshake when pending is set.
- **Wait counter:** width 3 bits, no wrap. With WAIT_STATES=0 each read phase lasts exactly one cycle.
- **Register timing:** outputs `flash_addr`, `flash_rd`, `instr*` are registered. Only `flash_ready` is combinational from state/pending.
- **Reset mid-read:** `flash_rd` drops asynchronously and the partial instruction is discarded.

## Structure
- **Shared package `uc_pkg`:** fetch state enum `fetch_state_t`, `INSTR_WIDTH`=16, `FLASH_DATA_WIDTH`=8.
- **One sub-module `fetch_pending_reg`:** single-entry address holding register (load, clear, valid flag), reusable for the data-memory path.
- **Top level:** the FSM, wait counter and output registers live directly in `instr_fetch`.

## Test plan
- **Reset/boot:** release `arst_n` with `pc_addr`=0x000 and `pc_valid`=1, flash bytes 0xA5,0x3C.
  - Expected: `flash_addr` 0x000 then 0x001, `instr`=0xA53C, `instr_pc`=0x000, `instr_valid` in cycle 7.
- **Back-to-back:** `pc_valid` at 0x010 then 0x011 one cycle later, `instr_ready` held 1.
  - Expected: 0x011 is held pending, `flash_ready`=0 throughout, and the second instruction has `instr_valid` 7 cycles after the first handshake.
- **Decoder stall:** `instr_ready`=0 for 5 cycles.
  - Expected: `instr`/`instr_pc` stable, `flash_rd`=0, and the handshake occurs on the cycle `instr_ready` rises.
- **Flush mid-RD_LO with `pc_valid` at 0x200 in the same cycle.**
  - Expected: pending cleared, the old instruction never becomes valid, and the next `flash_addr`=0x400.
- **WAIT_STATES=0 build.**
  - Expected: two `flash_rd` cycles per fetch and `instr_valid` at t+3.
- **Reset asserted in RD_HI with pending set.**
  - Expected: all outputs return to reset values and `flash_ready`=1 immediately.
